// File: rtl/i2c_slave_regfile.sv
// ============================================================================
// i2c_slave_regfile : byte register file behind an I2C slave byte stage.
// Build option: define I2C_REGFILE_AUTOINC_EN to auto-increment the pointer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_slave_regfile #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic              stop,
  input  logic              received,
  input  logic [7:0]        datareceive,
  input  logic              sended,
  output logic              receive,
  output logic              send,
  output logic [7:0]        datasend,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PTR   = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_adv;
  logic [7:0]          r_mem [DEPTH];
  logic [7:0]          r_datasend;
  logic [7:0]          r_host_rdata;
  logic                r_receive;
  logic                r_send;
  logic                r_wr_pulse;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                w_take_ptr;
  logic                w_take_wr;
  logic                w_take_rd;
  logic                w_rd_open;

  // A start always restarts the transaction, so byte events in that cycle are dropped.
  assign w_take_ptr = !start && (r_state == S_PTR)   && received;
  assign w_take_wr  = !start && (r_state == S_WDATA) && received;
  assign w_take_rd  = !start && (r_state == S_RDATA) && sended;
  assign w_rd_open  = start && rw;

`ifdef I2C_REGFILE_AUTOINC_EN
  assign w_ptr_adv = r_ptr + ADDR_W'(1);
`else
  assign w_ptr_adv = r_ptr;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = rw ? S_RDATA : S_PTR;
    end else if (stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_take_ptr) begin
      w_state_nxt = S_WDATA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_datasend <= 8'h00;
      r_receive  <= 1'b0;
      r_send     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_receive  <= (w_state_nxt == S_PTR) || (w_state_nxt == S_WDATA);
      r_send     <= (w_state_nxt == S_RDATA);
      r_wr_pulse <= w_take_wr;
      if (w_take_wr) begin
        r_wr_addr <= r_ptr;
      end
      if (w_take_ptr) begin
        r_ptr <= datareceive[ADDR_W-1:0];
      end else if (w_take_wr || w_take_rd) begin
        r_ptr <= w_ptr_adv;
      end
      if (w_rd_open) begin
        r_datasend <= r_mem[r_ptr];
      end else if (w_take_rd) begin
        r_datasend <= r_mem[w_ptr_adv];
      end
    end
  end

  // The I2C write is placed last so it overrides a host write to the same index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (host_we) begin
        r_mem[host_addr] <= host_wdata;
      end
      if (w_take_wr) begin
        r_mem[r_ptr] <= datareceive;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_host_rdata <= 8'h00;
    end else begin
      r_host_rdata <= r_mem[host_addr];
    end
  end

  assign receive    = r_receive;
  assign send       = r_send;
  assign datasend   = r_datasend;
  assign host_rdata = r_host_rdata;
  assign wr_pulse   = r_wr_pulse;
  assign wr_addr    = r_wr_addr;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
// Testbench for i2c_slave_regfile: directed scenarios plus randomized bus
// transactions compared against a transaction-level register-file model.
`default_nettype none

module tb_i2c_slave_regfile;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef I2C_REGFILE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, rw = 1'b0, stop = 1'b0;
  logic          received = 1'b0, sended = 1'b0, host_we = 1'b0;
  logic [7:0]    datareceive = 8'h00, host_wdata = 8'h00;
  logic [AW-1:0] host_addr = '0;
  logic          receive, send, wr_pulse;
  logic [7:0]    datasend, host_rdata;
  logic [AW-1:0] wr_addr;

  i2c_slave_regfile #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .stop(stop),
    .received(received), .datareceive(datareceive), .sended(sended),
    .receive(receive), .send(send), .datasend(datasend),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .wr_pulse(wr_pulse), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: register contents, pointer, last byte offered to the
  // master, and which part of a transaction the bus is in
  // (0 none, 1 awaiting pointer byte, 2 write data, 3 read data).
  logic [7:0] m_mem [DEPTH];
  int         m_ptr;
  int         m_phase;
  logic [7:0] m_ds;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".receive"}, 32'(receive), 32'((m_phase == 1) || (m_phase == 2)));
    chk({tag, ".send"},    32'(send),    32'(m_phase == 3));
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_ptr   = 0;
    m_phase = 0;
    m_ds    = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_clear();
    chk("rst.receive",    32'(receive),    32'd0);
    chk("rst.send",       32'(send),       32'd0);
    chk("rst.wr_pulse",   32'(wr_pulse),   32'd0);
    chk("rst.wr_addr",    32'(wr_addr),    32'd0);
    chk("rst.datasend",   32'(datasend),   32'd0);
    chk("rst.host_rdata", 32'(host_rdata), 32'd0);
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic bus_start(input logic dir, input bit with_stop);
    start = 1'b1; rw = dir; stop = with_stop;
    tick();
    start = 1'b0; rw = 1'b0; stop = 1'b0;
    m_phase = dir ? 3 : 1;
    if (dir) m_ds = m_mem[m_ptr];
    chk_flags("start");
    chk("start.wr_pulse", 32'(wr_pulse), 32'd0);
    if (dir) chk("start.datasend", 32'(datasend), 32'(m_ds));
  endtask

  task automatic bus_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    m_phase = 0;
    chk_flags("stop");
    chk("stop.wr_pulse", 32'(wr_pulse), 32'd0);
  endtask

  task automatic bus_byte(input logic [7:0] b, input bit with_stop,
                          input bit hw, input int ha, input logic [7:0] hd);
    bit exp_pulse;
    int exp_addr;
    received = 1'b1; datareceive = b; stop = with_stop;
    host_we = hw; host_addr = AW'(ha); host_wdata = hd;
    tick();
    received = 1'b0; stop = 1'b0; host_we = 1'b0;
    exp_pulse = 1'b0;
    exp_addr  = 0;
    if (hw) m_mem[ha] = hd;
    if (m_phase == 1) begin
      m_ptr   = b % DEPTH;
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_mem[m_ptr] = b;
      exp_pulse = 1'b1;
      exp_addr  = m_ptr;
      if (AUTOINC) m_ptr = (m_ptr + 1) % DEPTH;
    end
    if (with_stop) m_phase = 0;
    chk("byte.wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
    if (exp_pulse) chk("byte.wr_addr", 32'(wr_addr), 32'(exp_addr));
    chk_flags("byte");
  endtask

  task automatic bus_sended(input bit with_stop);
    sended = 1'b1; stop = with_stop;
    tick();
    sended = 1'b0; stop = 1'b0;
    if (m_phase == 3) begin
      if (AUTOINC) m_ptr = (m_ptr + 1) % DEPTH;
      m_ds = m_mem[m_ptr];
    end
    if (with_stop) m_phase = 0;
    chk("sended.datasend", 32'(datasend), 32'(m_ds));
    chk_flags("sended");
  endtask

  task automatic host_read(input int a);
    host_addr = AW'(a);
    tick();
    chk("host_rdata", 32'(host_rdata), 32'(m_mem[a]));
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    host_we = 1'b1; host_addr = AW'(a); host_wdata = d;
    tick();
    host_we = 1'b0;
    m_mem[a] = d;
  endtask

  initial begin
    model_clear();
    tick();
    do_reset();
    for (int i = 0; i < DEPTH; i++) host_read(i);

    // Pointer 3, two data bytes, stop.
    bus_start(1'b0, 1'b0);
    bus_byte(8'h03, 1'b0, 1'b0, 0, 8'h00);
    bus_byte(8'hA5, 1'b0, 1'b0, 0, 8'h00);
    bus_byte(8'h5A, 1'b0, 1'b0, 0, 8'h00);
    bus_stop();
    host_read(3);
    host_read(4);

    // Pointer write, repeated start into a read of three bytes.
    bus_start(1'b0, 1'b0);
    bus_byte(8'h03, 1'b0, 1'b0, 0, 8'h00);
    bus_start(1'b1, 1'b0);
    bus_sended(1'b0);
    bus_sended(1'b0);
    bus_sended(1'b0);
    bus_stop();

    // Pointer wrap at the top index; upper pointer bits ignored.
    bus_start(1'b0, 1'b0);
    bus_byte(8'hFF, 1'b0, 1'b0, 0, 8'h00);
    bus_byte(8'h11, 1'b0, 1'b0, 0, 8'h00);
    bus_byte(8'h22, 1'b0, 1'b0, 0, 8'h00);
    bus_stop();
    host_read(15);
    host_read(0);

    // Host and I2C writes colliding, then on different indices.
    bus_start(1'b0, 1'b0);
    bus_byte(8'h05, 1'b0, 1'b0, 0, 8'h00);
    bus_byte(8'h99, 1'b0, 1'b1, 5, 8'h77);
    host_read(5);
    bus_byte(8'h42, 1'b0, 1'b1, 9, 8'h33);
    bus_stop();
    host_read(9);
    host_read(5);
    host_read(6);

    // Start beats a coincident stop; byte with stop is written then idle.
    bus_start(1'b0, 1'b1);
    bus_byte(8'h07, 1'b0, 1'b0, 0, 8'h00);
    bus_byte(8'h66, 1'b1, 1'b0, 0, 8'h00);
    host_read(7);
    bus_start(1'b1, 1'b0);
    bus_sended(1'b1);

    // Reset in the middle of a write, then stray strobes while idle.
    bus_start(1'b0, 1'b0);
    bus_byte(8'h02, 1'b0, 1'b0, 0, 8'h00);
    bus_byte(8'hAB, 1'b0, 1'b0, 0, 8'h00);
    do_reset();
    bus_byte(8'hCD, 1'b0, 1'b0, 0, 8'h00);
    bus_sended(1'b0);
    for (int i = 0; i < DEPTH; i++) host_read(i);

    // Randomized transactions.
    for (int it = 0; it < 60; it++) begin
      int op;
      int n;
      op = int'($urandom_range(0, 4));
      case (op)
        0: begin
          bus_start(1'b0, 1'b0);
          bus_byte(8'($urandom), 1'b0, 1'b0, 0, 8'h00);
          n = int'($urandom_range(0, 4));
          for (int k = 0; k < n; k++) begin
            bus_byte(8'($urandom), 1'b0, ($urandom_range(0, 3) == 0),
                     int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
          end
          if ($urandom_range(0, 1) == 1) bus_byte(8'($urandom), 1'b1, 1'b0, 0, 8'h00);
          else bus_stop();
        end
        1: begin
          bus_start(1'b1, 1'b0);
          n = int'($urandom_range(1, 4));
          for (int k = 0; k < n; k++) bus_sended(1'b0);
          bus_stop();
        end
        2: begin
          bus_start(1'b0, 1'b0);
          bus_byte(8'($urandom), 1'b0, 1'b0, 0, 8'h00);
          bus_start(1'b1, 1'b0);
          n = int'($urandom_range(0, 3));
          for (int k = 0; k < n; k++) bus_sended(1'b0);
          bus_sended(1'b1);
        end
        3: host_write(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
        default: begin
          bus_byte(8'($urandom), 1'b0, 1'b0, 0, 8'h00);
          bus_sended(1'b0);
          host_read(int'($urandom_range(0, DEPTH - 1)));
        end
      endcase
    end
    for (int i = 0; i < DEPTH; i++) host_read(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the register-index width; depth = 2^ADDR_W bytes.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-clk pulse from the slave stage on START or repeated START with matching address.
REQ-005 rw  input  1  direction, valid with start: 0 = master writes, 1 = master reads.
REQ-006 stop  input  1  one-clk pulse on bus STOP.
REQ-007 received  input  1  one-clk pulse: datareceive holds a new byte.
REQ-008 datareceive  input  8  byte from the slave stage.
REQ-009 sended  input  1  one-clk pulse: the slave stage consumed datasend and needs the next byte.
REQ-010 receive  output  1  to slave: accept further write bytes.
REQ-011 send  output  1  to slave: datasend is valid, keep supplying read bytes.
REQ-012 datasend  output  8  next byte for the slave stage to shift out.
REQ-013 host_addr  input  ADDR_W  local register index.
REQ-014 host_we  input  1  local write strobe.
REQ-015 host_wdata  input  8  local write data.
REQ-016 host_rdata  output  8  reg[host_addr], registered, 1-clk latency.
REQ-017 wr_pulse  output  1  one-clk pulse per register written from I2C.
REQ-018 wr_addr  output  ADDR_W  index written, valid with wr_pulse.

Function
REQ-019 States SHALL be IDLE, PTR, WDATA, RDATA.
REQ-020 IDLE/any state: start & !rw SHALL go to PTR; start & rw SHALL go to RDATA; stop SHALL go to IDLE.
REQ-021 start and stop in the same cycle: start SHALL win.
REQ-022 PTR: received SHALL load ptr <= datareceive[ADDR_W-1:0] (upper bits ignored) and go to WDATA.
REQ-023 WDATA: received SHALL write reg[ptr] <= datareceive, pulse wr_pulse with wr_addr = ptr next cycle, then advance ptr per REQ-031.
REQ-024 Entering RDATA: datasend SHALL equal reg[ptr] on the cycle after start, before any sended.
REQ-025 RDATA: sended SHALL advance ptr and reload datasend from reg[new ptr] within 1 clk.
REQ-026 receive SHALL be 1 only in PTR and WDATA; send SHALL be 1 only in RDATA.
REQ-027 ptr increment SHALL wrap from 2^ADDR_W-1 to 0; ptr SHALL persist across transactions (write-pointer-then-repeated-start-read works).
REQ-028 received outside PTR/WDATA and sended outside RDATA SHALL be ignored.
REQ-029 received or sended coincident with stop: byte SHALL be processed, then IDLE.
REQ-030 host_we and I2C write to the same index in one cycle: I2C value SHALL win; different indices both SHALL take effect.

Configuration
REQ-031 Macro I2C_REGFILE_AUTOINC_EN defined: ptr SHALL increment after each WDATA write and each RDATA sended; undefined: ptr SHALL stay fixed until reloaded in PTR (repeated access to one register).

Reset
REQ-032 reset low SHALL immediately force state IDLE, ptr 0, all registers 0x00, datasend 0x00, host_rdata 0x00, receive/send/wr_pulse 0, wr_addr 0.
REQ-033 reset asserted mid-transaction SHALL abandon it; after release, no write SHALL occur until a new start.

Verification
REQ-034 start,rw=0; bytes 0x03,0xA5,0x5A; stop -> reg3=0xA5, reg4=0x5A, two wr_pulse with wr_addr 3,4, state IDLE.
REQ-035 After REQ-034, start,rw=0; byte 0x03; start,rw=1; three sended -> datasend 0xA5, 0x5A, 0x00 in order.
REQ-036 Write at ptr 0x0F, bytes 0x11,0x22 -> reg15=0x11, reg0=0x22 (wrap); without I2C_REGFILE_AUTOINC_EN -> reg15=0x22, reg0 unchanged.
REQ-037 host_we addr 5 data 0x77 same cycle as I2C write 0x99 to reg5 -> reg5=0x99; host_rdata at addr 5 next clk = 0x99.
REQ-038 reset low between two WDATA bytes -> all registers 0x00, receive 0; later stray received pulse -> no write.
